mult_seq_ctrl: RTL

//  Iterative unsigned shift-add multiplier sequencer for the processor datapath.
//  - Each cycle, forms one partial product with a per-bit AND array
//    (multiplicand AND {WIDTH{multiplier bit}}) and accumulates it.
//  - Sequences WIDTH iterations and raises a one-cycle done pulse.
//  - Holds the 2*WIDTH-bit product for the writeback mux.
//  - Sits beside the ALU and stalls the pipeline through busy.

---
 rtl/mult_seq_ctrl.sv | 108 ++++++++++
 1 files changed

// File: rtl/mult_seq_ctrl.sv
// mult_seq_ctrl
//   Iterative unsigned shift-add multiplier sequencer. It retires one
//   multiplier bit per clock. Each cycle it ANDs the multiplicand with the
//   current low bit of the accumulator, adds the result into the upper half,
//   and shifts the 2*WIDTH-bit accumulator right by one bit. The carry of that
//   add is kept, so the arithmetic is exact. After WIDTH iterations the
//   product is latched and done pulses for one cycle.
//
// Ports
//   clk           rising-edge clock
//   reset         asynchronous, active-high reset
//   start         multiply request; accepted in IDLE or in the DONE cycle
//   multiplicand  operand A, captured on acceptance
//   multiplier    operand B, captured on acceptance
//   busy          high while iterating (RUN)
//   done          one-cycle pulse; product is valid from this cycle
//   product       2*WIDTH-bit unsigned A*B, held until the next done
module mult_seq_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] product
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    logic [1:0]         state;
    logic [WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]   acc_hi;
    logic [WIDTH-1:0]   acc_lo;
    logic [CNT_W-1:0]   count;

    logic [WIDTH-1:0]   pp;
    logic [WIDTH:0]     sum_c;
    logic [2*WIDTH-1:0] acc_next;
    logic               accept;

    // One shift-add step. The carry out of the add becomes the new top
    // accumulator bit as the pair shifts right.
    always_comb begin
        pp       = mcand_reg & {WIDTH{acc_lo[0]}};
        sum_c    = {1'b0, acc_hi} + {1'b0, pp};
        acc_next = {sum_c, acc_lo[WIDTH-1:1]};
    end

    // A new operation can start from IDLE, or directly from the DONE cycle.
    always_comb begin
        accept = start && ((state == ST_IDLE) || (state == ST_DONE));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            mcand_reg <= '0;
            acc_hi    <= '0;
            acc_lo    <= '0;
            count     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            product   <= '0;
        end else begin
            case (state)
                ST_RUN: begin
                    {acc_hi, acc_lo} <= acc_next;
                    count            <= count + 1'b1;
                    // The product register is loaded from the final step directly,
                    // so it is already valid in the cycle where done is high.
                    if (count == LAST_ITER) begin
                        state   <= ST_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        product <= acc_next;
                    end
                end
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (accept) begin
                        mcand_reg <= multiplicand;
                        acc_hi    <= '0;
                        acc_lo    <= multiplier;
                        count     <= '0;
                        state     <= ST_RUN;
                        busy      <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
